// File: rtl/rldramii_dmaster_pkt_pkg.sv
// Shared byte-stream packet encoding: special symbols, escape mask, decoder states and beat payload.
// Used by both the bytes-to-packets decoder and the matching encoder.
package rldramii_dmaster_pkt_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] SYM_SOP  = 8'h7A;
   localparam logic [BYTE_W-1:0] SYM_EOP  = 8'h7B;
   localparam logic [BYTE_W-1:0] SYM_CHAN = 8'h7C;
   localparam logic [BYTE_W-1:0] SYM_ESC  = 8'h7D;
   localparam logic [BYTE_W-1:0] ESC_XOR  = 8'h20;

   typedef enum logic [1:0] {
      ST_DATA     = 2'd0,
      ST_ESC      = 2'd1,
      ST_CHAN     = 2'd2,
      ST_CHAN_ESC = 2'd3
   } dec_state_e;

   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              sop;
      logic              eop;
      logic [BYTE_W-1:0] channel;
   } beat_t;

   // SOP, EOP and channel markers: the bytes that cannot be a channel value
   function automatic logic is_marker(input logic [BYTE_W-1:0] b);
      return (b == SYM_SOP) || (b == SYM_EOP) || (b == SYM_CHAN);
   endfunction

endpackage

// File: rtl/rldramii_dmaster_pipe_reg.sv
// One-deep valid/ready output register for decoded beats; ready is combinational
// so a new beat can be loaded in the same cycle the held one is taken.
module rldramii_dmaster_pipe_reg
   import rldramii_dmaster_pkt_pkg::*;
#(
   parameter logic [BYTE_W-1:0] CHANNEL_RESET = 8'h00
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  i_valid,
   input  beat_t i_beat,
   output logic  o_ready_c,
   input  logic  i_ready,
   output logic  o_valid,
   output beat_t o_beat
);

   logic  r_valid;
   beat_t r_beat;

   assign o_ready_c = !r_valid || i_ready;
   assign o_valid   = r_valid;
   assign o_beat    = r_beat;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_beat  <= beat_t'{data: '0, sop: 1'b0, eop: 1'b0, channel: CHANNEL_RESET};
      end else if (o_ready_c) begin
         r_valid <= i_valid;
         if (i_valid) r_beat <= i_beat;
      end
   end

endmodule

// File: rtl/rldramii_dmaster_bytes_to_packets.sv
// Decodes an escaped byte stream (SOP/EOP/channel/escape markers) into packet beats
// with start/end flags and channel, through a single output register.
module rldramii_dmaster_bytes_to_packets
   import rldramii_dmaster_pkt_pkg::*;
#(
   parameter logic [7:0] CHANNEL_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   output logic       in_ready,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_startofpacket,
   output logic       out_endofpacket,
   output logic [7:0] out_channel,
   output logic       proto_err
);

   dec_state_e  r_state;
   logic        r_sop_pend;
   logic        r_eop_pend;
   logic        r_in_pkt;
   logic [7:0]  r_chan;
   logic        r_proto_err;

   dec_state_e  w_state_nxt;
   logic        w_sop_nxt;
   logic        w_eop_nxt;
   logic        w_in_pkt_nxt;
   logic [7:0]  w_chan_nxt;
   logic        w_err;
   logic        w_emit;
   logic        w_as_data;
   logic [7:0]  w_emit_data;
   logic        w_ready_c;
   logic        w_accept;
   beat_t       w_beat;
   beat_t       w_out_beat;

   assign w_accept = in_valid && w_ready_c;
   assign in_ready = w_ready_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_DATA;
         r_sop_pend  <= 1'b0;
         r_eop_pend  <= 1'b0;
         r_in_pkt    <= 1'b0;
         r_chan      <= CHANNEL_RESET;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sop_pend  <= w_sop_nxt;
         r_eop_pend  <= w_eop_nxt;
         r_in_pkt    <= w_in_pkt_nxt;
         r_chan      <= w_chan_nxt;
         r_proto_err <= w_err;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sop_nxt    = r_sop_pend;
      w_eop_nxt    = r_eop_pend;
      w_in_pkt_nxt = r_in_pkt;
      w_chan_nxt   = r_chan;
      w_err        = 1'b0;
      w_emit       = 1'b0;
      w_as_data    = 1'b0;
      w_emit_data  = in_data;

      if (w_accept) begin
         unique case (r_state)
            ST_DATA: w_as_data = 1'b1;
            ST_ESC: begin
               w_emit      = 1'b1;
               w_emit_data = in_data ^ ESC_XOR;
               w_state_nxt = ST_DATA;
            end
            ST_CHAN: begin
               if (in_data == SYM_ESC) begin
                  w_state_nxt = ST_CHAN_ESC;
               end else if (is_marker(in_data)) begin
                  // Channel field cut short by a marker: flag it, then treat the marker normally
                  w_err     = 1'b1;
                  w_as_data = 1'b1;
               end else begin
                  w_chan_nxt  = in_data;
                  w_state_nxt = ST_DATA;
               end
            end
            ST_CHAN_ESC: begin
               w_chan_nxt  = in_data ^ ESC_XOR;
               w_state_nxt = ST_DATA;
            end
            default: w_state_nxt = ST_DATA;
         endcase
      end

      if (w_as_data) begin
         w_state_nxt = ST_DATA;
         if (in_data == SYM_SOP) begin
            w_sop_nxt    = 1'b1;
            w_eop_nxt    = 1'b0;
            w_in_pkt_nxt = 1'b1;
         end else if (in_data == SYM_EOP) begin
            w_eop_nxt = 1'b1;
         end else if (in_data == SYM_CHAN) begin
            w_state_nxt = ST_CHAN;
         end else if (in_data == SYM_ESC) begin
            w_state_nxt = ST_ESC;
         end else begin
            w_emit = 1'b1;
         end
      end

      // An end-of-packet beat with no SOP since the last packet end is still delivered
      if (w_emit) begin
         w_sop_nxt = 1'b0;
         w_eop_nxt = 1'b0;
         if (r_eop_pend) begin
            w_in_pkt_nxt = 1'b0;
            if (!r_in_pkt) w_err = 1'b1;
         end
      end
   end

   assign w_beat = beat_t'{data: w_emit_data, sop: r_sop_pend, eop: r_eop_pend, channel: r_chan};

   rldramii_dmaster_pipe_reg #(
      .CHANNEL_RESET (CHANNEL_RESET)
   ) u_pipe_reg (
      .clk       (clk),
      .reset     (reset),
      .i_valid   (w_emit),
      .i_beat    (w_beat),
      .o_ready_c (w_ready_c),
      .i_ready   (out_ready),
      .o_valid   (out_valid),
      .o_beat    (w_out_beat)
   );

   assign out_data          = w_out_beat.data;
   assign out_startofpacket = w_out_beat.sop;
   assign out_endofpacket   = w_out_beat.eop;
   assign out_channel       = w_out_beat.channel;
   assign proto_err         = r_proto_err;

endmodule
